window_addr_gen: RTL and testbench

WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

---
 rtl/window_addr_gen.sv | 129 ++++++++++++
 tb/tb_window_addr_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// Sliding-window address generator for a line/word buffer.
// Each frame issues DEPTH read windows of NUM_RD consecutive taps starting
// at base 0..DEPTH-1, with wrap or clamp handling at the buffer edge, and
// issues one write per consumed window PIPE_LAT cycles later.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst_n    - synchronous active-low reset
//   start    - begins a frame when idle
//   mode     - edge mode latched on start: 0 = wrap, 1 = clamp
//   rd_en    - consumer accepts the current read window
//   rd_addr  - NUM_RD taps, tap k at [k*ADDR_W +: ADDR_W]
//   rd_valid - rd_addr holds a live window
//   wr_addr  - write address, 0..DEPTH-1 in order
//   wr_valid - a write is issued this cycle
//   busy     - high whenever not idle
//   done     - one-cycle end-of-frame pulse
module window_addr_gen #(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 3,
  parameter int PIPE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     rd_en,
  output logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_valid,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Widened so base + tap offset cannot overflow before wrap/clamp.
  localparam int SUM_W = ADDR_W + 4;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [SUM_W-1:0]  LAST_S  = SUM_W'(DEPTH - 1);
  localparam logic [SUM_W-1:0]  DEPTH_S = SUM_W'(DEPTH);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_mode;
  logic [PIPE_LAT-1:0] r_pipe;

  logic                w_consume;
  logic [SUM_W-1:0]    w_sum [NUM_RD];

  assign w_consume = (r_state == RUN) && rd_en;

  assign rd_valid = (r_state == RUN);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign wr_valid = r_pipe[PIPE_LAT-1];
  assign wr_addr  = r_wr_addr;

  // base < DEPTH and k < NUM_RD <= DEPTH, so the sum stays below 2*DEPTH
  // and a single conditional subtract implements the modulo.
  always_comb begin
    rd_addr = '0;
    w_sum   = '{default: '0};
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      w_sum[k] = SUM_W'(r_base) + SUM_W'(k);
      if (r_mode) begin
        if (w_sum[k] > LAST_S) w_sum[k] = LAST_S;
      end else if (w_sum[k] >= DEPTH_S) begin
        w_sum[k] = w_sum[k] - DEPTH_S;
      end
      rd_addr[k*ADDR_W +: ADDR_W] = w_sum[k][ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_wr_addr <= '0;
      r_mode    <= 1'b0;
      r_pipe    <= '0;
    end else begin
      // One bit per consumed window travels PIPE_LAT stages to become a write.
      r_pipe[0] <= w_consume;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (wr_valid) begin
        r_wr_addr <= (r_wr_addr == LAST) ? '0 : r_wr_addr + ADDR_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_base    <= '0;
            r_wr_addr <= '0;
            r_mode    <= mode;
          end
        end
        RUN: begin
          if (w_consume) begin
            if (r_base == LAST) begin
              r_base  <= '0;
              r_state <= DRAIN;
            end else begin
              r_base <= r_base + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // The DEPTH-th write is the one landing on the last address.
          if (wr_valid && (r_wr_addr == LAST)) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
module tb_window_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, rd_en;
  logic [11:0] rd_addr;
  logic        rd_valid, wr_valid, busy, done;
  logic [3:0]  wr_addr;

  logic        start2, mode2, rd_en2;
  logic [19:0] rd_addr2;
  logic        rd_valid2, wr_valid2, busy2, done2;
  logic [3:0]  wr_addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .wr_addr(wr_addr),
    .wr_valid(wr_valid), .busy(busy), .done(done)
  );

  window_addr_gen #(.ADDR_W(4), .DEPTH(8), .NUM_RD(5), .PIPE_LAT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .rd_en(rd_en2),
    .rd_addr(rd_addr2), .rd_valid(rd_valid2), .wr_addr(wr_addr2),
    .wr_valid(wr_valid2), .busy(busy2), .done(done2)
  );

  // Reference tap table: tap k = (base+k) mod depth, or min(base+k, depth-1).
  function automatic logic [31:0] model_taps(input int base, input int depth,
                                             input int ntaps, input bit clamp);
    logic [31:0] r;
    int t;
    r = '0;
    for (int k = 0; k < ntaps; k++) begin
      t = base + k;
      if (clamp) t = (t > depth - 1) ? depth - 1 : t;
      else       t = t % depth;
      r[k*4 +: 4] = t[3:0];
    end
    return r;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; start2 = 1'b0; rd_en2 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; rd_en = 1'b1; mode = 1'b1;
    start2 = 1'b1; rd_en2 = 1'b1; mode2 = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rd_addr !== 12'h210) begin errors++; $display("FAIL reset_rd_addr: got %h expected 210", rd_addr); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    rst_n = 1'b1; start = 1'b0; rd_en = 1'b0; start2 = 1'b0; rd_en2 = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  // Full frame with rd_en held high; cyc 0 is the first RUN cycle.
  task automatic test_frame(input bit m);
    logic [31:0] exp;
    int dones, writes;
    dones = 0; writes = 0;
    @(negedge clk);
    mode = m; start = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 19; cyc++) begin
      checks++; if (rd_valid !== (cyc < 16)) begin errors++; $display("FAIL frame_rd_valid: cyc %0d got %b expected %b", cyc, rd_valid, cyc < 16); end
      if (cyc < 16) begin
        exp = model_taps(cyc, 16, 3, m);
        checks++; if ({20'b0, rd_addr} !== exp) begin errors++; $display("FAIL frame_rd_addr: mode %0d cyc %0d got %h expected %h", m, cyc, rd_addr, exp[11:0]); end
      end
      if (m && cyc == 14) begin
        checks++; if (rd_addr !== 12'hFFE) begin errors++; $display("FAIL clamp_window14: got %h expected ffe", rd_addr); end
      end
      if (m && cyc == 15) begin
        checks++; if (rd_addr !== 12'hFFF) begin errors++; $display("FAIL clamp_window15: got %h expected fff", rd_addr); end
      end
      checks++; if (wr_valid !== (cyc >= 1 && cyc <= 16)) begin errors++; $display("FAIL frame_wr_valid: cyc %0d got %b", cyc, wr_valid); end
      if (wr_valid) begin
        writes++;
        checks++; if (wr_addr !== 4'(cyc - 1)) begin errors++; $display("FAIL frame_wr_addr: cyc %0d got %0d expected %0d", cyc, wr_addr, cyc - 1); end
      end
      if (done) dones++;
      checks++; if (done !== (cyc == 17)) begin errors++; $display("FAIL frame_done: cyc %0d got %b expected %b", cyc, done, cyc == 17); end
      checks++; if (busy !== (cyc <= 17)) begin errors++; $display("FAIL frame_busy: cyc %0d got %b expected %b", cyc, busy, cyc <= 17); end
      @(negedge clk);
    end
    rd_en = 1'b0;
    checks++; if (writes !== 16) begin errors++; $display("FAIL frame_write_count: got %0d expected 16", writes); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_rd_en_gaps();
    logic [31:0] exp;
    int base_m;
    bit prev;
    base_m = 0; prev = 1'b0;
    @(negedge clk);
    mode = 1'b0; start = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      rd_en = (c < 8) && (c % 2 == 0);
      exp = model_taps(base_m, 16, 3, 1'b0);
      checks++; if ({20'b0, rd_addr} !== exp) begin errors++; $display("FAIL gap_rd_addr: c %0d got %h expected %h", c, rd_addr, exp[11:0]); end
      checks++; if (wr_valid !== prev) begin errors++; $display("FAIL gap_wr_valid: c %0d got %b expected %b", c, wr_valid, prev); end
      prev = rd_en;
      if (rd_en) base_m++;
      @(negedge clk);
    end
    apply_reset();
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    mode = 1'b0; start = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rd_addr !== 12'h765) begin errors++; $display("FAIL ign_pre_base5: got %h expected 765", rd_addr); end
    rd_en = 1'b0; start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_en = 1'b1;
    checks++; if (rd_addr !== 12'h765) begin errors++; $display("FAIL ign_base_hold: got %h expected 765", rd_addr); end
    checks++; if (wr_addr !== 4'd5) begin errors++; $display("FAIL ign_wr_addr: got %0d expected 5", wr_addr); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL ign_rd_valid: got %b expected 1", rd_valid); end
    @(negedge clk);
    checks++; if (rd_addr !== 12'h876) begin errors++; $display("FAIL ign_base6: got %h expected 876", rd_addr); end
    repeat (8) @(negedge clk);
    checks++; if (rd_addr !== 12'h0FE) begin errors++; $display("FAIL ign_mode_kept: got %h expected 0fe", rd_addr); end
    checks++; if (wr_valid !== 1'b1 || wr_addr !== 4'd13) begin errors++; $display("FAIL ign_wr_progress: got valid %b addr %0d expected 1 13", wr_valid, wr_addr); end
    apply_reset();
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    mode = 1'b0; start = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (rd_addr !== 12'h987 || wr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got addr %h valid %b expected 987 1", rd_addr, wr_valid); end
    rst_n = 1'b0; start = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_addr !== 12'h210) begin errors++; $display("FAIL mid_base0: got %h expected 210", rd_addr); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL mid_wr_addr: got %0d expected 0", wr_addr); end
    rst_n = 1'b1; start = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_flush: got valid %b busy %b expected 0 0", wr_valid, busy); end
    test_frame(1'b0);
  endtask

  // DEPTH=8, NUM_RD=5, PIPE_LAT=4: writes land on cycles 4..11, done on 12.
  task automatic test_param_instance();
    logic [31:0] exp;
    int writes, dones;
    writes = 0; dones = 0;
    @(negedge clk);
    mode2 = 1'b0; start2 = 1'b1; rd_en2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      checks++; if (rd_valid2 !== (cyc < 8)) begin errors++; $display("FAIL p_rd_valid: cyc %0d got %b", cyc, rd_valid2); end
      if (cyc < 8) begin
        exp = model_taps(cyc, 8, 5, 1'b0);
        checks++; if ({12'b0, rd_addr2} !== exp) begin errors++; $display("FAIL p_rd_addr: cyc %0d got %h expected %h", cyc, rd_addr2, exp[19:0]); end
      end
      if (cyc == 7) begin
        checks++; if (rd_addr2 !== 20'h32107) begin errors++; $display("FAIL p_last_window: got %h expected 32107", rd_addr2); end
      end
      checks++; if (wr_valid2 !== (cyc >= 4 && cyc <= 11)) begin errors++; $display("FAIL p_wr_valid: cyc %0d got %b", cyc, wr_valid2); end
      if (wr_valid2) begin
        writes++;
        checks++; if (wr_addr2 !== 4'(cyc - 4)) begin errors++; $display("FAIL p_wr_addr: cyc %0d got %0d expected %0d", cyc, wr_addr2, cyc - 4); end
      end
      if (done2) dones++;
      checks++; if (done2 !== (cyc == 12)) begin errors++; $display("FAIL p_done: cyc %0d got %b", cyc, done2); end
      checks++; if (busy2 !== (cyc <= 12)) begin errors++; $display("FAIL p_busy: cyc %0d got %b", cyc, busy2); end
      @(negedge clk);
    end
    rd_en2 = 1'b0;
    checks++; if (writes !== 8) begin errors++; $display("FAIL p_write_count: got %0d expected 8", writes); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL p_done_count: got %0d expected 1", dones); end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_rd_en_gaps();
    test_start_ignored();
    test_reset_midframe();
    test_param_instance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
